// File: rtl/wave_play_pkg.sv
// Shared types, constants and the sample scaling helper for the waveform playback sequencer.
package wave_play_pkg;

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [ACC_W-1:0]  STEP_BASE = 24'h010000;
  localparam logic [DATA_W-1:0] MIDSCALE  = 8'h80;
  localparam logic [2:0]        FREQ_MAX  = 3'd7;
  localparam logic [1:0]        AMP_MAX   = 2'd3;

  typedef enum logic [1:0] {WAVE_SIN, WAVE_SQ, WAVE_SAW, WAVE_TRI} wave_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SWITCH} state_e;

  // Attenuate around midscale: offset-binary -> signed, arithmetic shift, back to offset-binary.
  function automatic logic [DATA_W-1:0] scale_sample(input logic [DATA_W-1:0] q,
                                                     input logic [1:0]        shift);
    logic signed [DATA_W:0] s;
    logic signed [DATA_W:0] t;
    s = $signed({1'b0, q}) - $signed({1'b0, MIDSCALE});
    t = s >>> shift;
    return MIDSCALE + t[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/wave_play_ctrl_if.sv
// Key, ROM and sample-output signals of the waveform sequencer.
// sweep_en exists only when WAVE_SWEEP_EN is defined.
interface wave_play_ctrl_if;
  import wave_play_pkg::*;

`ifdef WAVE_SWEEP_EN
  logic              sweep_en;
`endif
  logic              run_en;
  logic              key_sel;
  logic              key_freq;
  logic              key_amp;
  logic [DATA_W-1:0] rom_q_sin;
  logic [DATA_W-1:0] rom_q_sq;
  logic [DATA_W-1:0] rom_q_saw;
  logic [DATA_W-1:0] rom_q_tri;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rden;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [1:0]        wave_sel;
  logic [2:0]        freq_idx;
  logic [1:0]        amp_shift;

  modport master (
`ifdef WAVE_SWEEP_EN
    input  sweep_en,
`endif
    input  run_en, key_sel, key_freq, key_amp,
    input  rom_q_sin, rom_q_sq, rom_q_saw, rom_q_tri,
    output rom_addr, rom_rden, dout, dout_valid, wave_sel, freq_idx, amp_shift
  );

  modport slave (
`ifdef WAVE_SWEEP_EN
    output sweep_en,
`endif
    output run_en, key_sel, key_freq, key_amp,
    output rom_q_sin, rom_q_sq, rom_q_saw, rom_q_tri,
    input  rom_addr, rom_rden, dout, dout_valid, wave_sel, freq_idx, amp_shift
  );

endinterface

// File: rtl/wave_phase_acc.sv
// Phase accumulator: adds step while enabled, clear wins; wrap is the carry out of acc+step.
module wave_phase_acc #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] step,
  output logic [ACC_W-1:0] acc,
  output logic             wrap
);

  logic [ACC_W:0] sum;

  assign sum  = {1'b0, acc} + {1'b0, step};
  assign wrap = en & sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/wave_play_ctrl.sv
// Waveform playback sequencer: FSM, key handling, ROM addressing and output scaling.
// Optional WAVE_SWEEP_EN adds a frequency sweep that advances freq_idx on every phase wrap.
module wave_play_ctrl
  import wave_play_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  wave_play_ctrl_if.master bus
);

  state_e            state;
  logic [ACC_W-1:0]  step;
  logic [ACC_W-1:0]  acc;
  logic              wrap;
  logic              acc_clr;
  logic              acc_en;
  logic              rden;
  logic [1:0]        wave_sel;
  logic [1:0]        pend_sel;
  logic [1:0]        pend_next;
  logic [2:0]        freq_idx;
  logic [2:0]        freq_next;
  logic              freq_adv;
  logic [1:0]        amp_shift;
  logic [1:0]        amp_next;
  logic [1:0]        wave_d1;
  logic [1:0]        amp_d1;
  logic              rden_d1;
  logic [DATA_W-1:0] rom_q_mux;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              unused_acc_lo;

  assign step    = STEP_BASE << freq_idx;
  assign acc_en  = (state != ST_IDLE);
  assign acc_clr = !bus.run_en || (state == ST_IDLE);

  wave_phase_acc #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .step  (step),
    .acc   (acc),
    .wrap  (wrap)
  );

  assign unused_acc_lo = ^acc[ACC_W-ADDR_W-1:0];

  assign pend_next = pend_sel + {1'b0, bus.key_sel};
  assign freq_next = (freq_idx == FREQ_MAX) ? 3'd0 : freq_idx + 3'd1;
  assign amp_next  = (amp_shift == AMP_MAX) ? 2'd0 : amp_shift + 2'd1;

`ifdef WAVE_SWEEP_EN
  assign freq_adv = bus.sweep_en ? wrap : bus.key_freq;
`else
  assign freq_adv = bus.key_freq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rden      <= 1'b0;
      wave_sel  <= 2'd0;
      pend_sel  <= 2'd0;
      freq_idx  <= 3'd0;
      amp_shift <= 2'd0;
    end else begin
      if (state != ST_IDLE) begin
        if (freq_adv)    freq_idx  <= freq_next;
        if (bus.key_amp) amp_shift <= amp_next;
      end
      unique case (state)
        ST_IDLE: begin
          pend_sel <= 2'd0;
          if (bus.run_en) begin
            state <= ST_RUN;
            rden  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!bus.run_en) begin
            state <= ST_IDLE;
            rden  <= 1'b0;
          end else if (bus.key_sel) begin
            // A press coincident with a wrap only arms the switch for the next wrap.
            pend_sel <= wave_sel + 2'd1;
            state    <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          if (!bus.run_en) begin
            state    <= ST_IDLE;
            rden     <= 1'b0;
            pend_sel <= 2'd0;
          end else if (wrap) begin
            wave_sel <= pend_next;
            state    <= ST_RUN;
          end else begin
            pend_sel <= pend_next;
          end
        end
        default: begin
          state <= ST_IDLE;
          rden  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rom_q_mux = bus.rom_q_sin;
    unique case (wave_e'(wave_d1))
      WAVE_SIN: rom_q_mux = bus.rom_q_sin;
      WAVE_SQ:  rom_q_mux = bus.rom_q_sq;
      WAVE_SAW: rom_q_mux = bus.rom_q_saw;
      WAVE_TRI: rom_q_mux = bus.rom_q_tri;
    endcase
  end

  // wave_d1/amp_d1 line up with rom_q, which lags the address by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_d1    <= 2'd0;
      amp_d1     <= 2'd0;
      rden_d1    <= 1'b0;
      dout       <= MIDSCALE;
      dout_valid <= 1'b0;
    end else begin
      wave_d1    <= wave_sel;
      amp_d1     <= amp_shift;
      rden_d1    <= rden;
      dout_valid <= rden_d1;
      dout       <= rden_d1 ? scale_sample(rom_q_mux, amp_d1) : MIDSCALE;
    end
  end

  assign bus.rom_addr   = acc[ACC_W-1 -: ADDR_W];
  assign bus.rom_rden   = rden;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.wave_sel   = wave_sel;
  assign bus.freq_idx   = freq_idx;
  assign bus.amp_shift  = amp_shift;

endmodule

// File: tb/tb_wave_play_ctrl.sv
// Directed self-checking bench for wave_play_ctrl (sweep checks active with WAVE_SWEEP_EN).
module tb_wave_play_ctrl;
  import wave_play_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sin_q = 8'h00;
  logic [7:0] exp_addr;
  int         n_checks = 0;
  int         n_fail = 0;

  wave_play_ctrl_if bus ();

  wave_play_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Sin ROM model: registered read returning the address, so dout exposes pipeline alignment.
  always @(posedge clk) if (bus.rom_rden) sin_q <= bus.rom_addr;
  assign bus.rom_q_sin = sin_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_until_addr(input logic [7:0] a);
    int n = 0;
    while (bus.rom_addr != a && n < 600) begin
      tick();
      n++;
    end
    check("reach_addr", {24'd0, bus.rom_addr}, {24'd0, a});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},  {24'd0, bus.rom_addr}, 32'h00);
    check({tag, "_rden"},  {31'd0, bus.rom_rden}, 32'h0);
    check({tag, "_dout"},  {24'd0, bus.dout},     32'h80);
    check({tag, "_valid"}, {31'd0, bus.dout_valid}, 32'h0);
    check({tag, "_wave"},  {30'd0, bus.wave_sel}, 32'h0);
    check({tag, "_freq"},  {29'd0, bus.freq_idx}, 32'h0);
    check({tag, "_amp"},   {30'd0, bus.amp_shift}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;
    rst_n         = 1'b0;
    bus.run_en    = 1'b0;
    bus.key_sel   = 1'b0;
    bus.key_freq  = 1'b0;
    bus.key_amp   = 1'b0;
    bus.rom_q_sq  = 8'h22;
    bus.rom_q_saw = 8'hFF;
    bus.rom_q_tri = 8'h33;
`ifdef WAVE_SWEEP_EN
    bus.sweep_en  = 1'b0;
`endif
    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();
    check("idle_rden", {31'd0, bus.rom_rden}, 32'h0);

    // 1: free-running address ramp at freq_idx 0
    bus.run_en = 1'b1;
    tick();
    check("t1_rden", {31'd0, bus.rom_rden}, 32'h1);
    check("t1_addr0", {24'd0, bus.rom_addr}, 32'h0);
    check("t1_valid0", {31'd0, bus.dout_valid}, 32'h0);
    for (int i = 1; i <= 256; i++) begin
      tick();
      e = 8'(i);
      check("t1_addr", {24'd0, bus.rom_addr}, {24'd0, e});
      if (i == 1) begin
        check("t1_valid1", {31'd0, bus.dout_valid}, 32'h0);
        check("t1_dout1", {24'd0, bus.dout}, 32'h80);
      end else begin
        e = 8'(i - 2);
        check("t1_valid", {31'd0, bus.dout_valid}, 32'h1);
        check("t1_dout", {24'd0, bus.dout}, {24'd0, e});
      end
    end

    // 3a: two presses before the wrap -> wave 2 at the wrap
    run_until_addr(8'h40);
    bus.key_sel = 1'b1; tick(); bus.key_sel = 1'b0;
    check("t3a_hold", {30'd0, bus.wave_sel}, 32'h0);
    run_until_addr(8'h80);
    bus.key_sel = 1'b1; tick(); bus.key_sel = 1'b0;
    run_until_addr(8'hFF);
    check("t3a_prewrap", {30'd0, bus.wave_sel}, 32'h0);
    tick();
    check("t3a_wrap_addr", {24'd0, bus.rom_addr}, 32'h0);
    check("t3a_wave", {30'd0, bus.wave_sel}, 32'h2);
    tick(); tick();
    check("t3a_dout_saw", {24'd0, bus.dout}, 32'hFF);

    // 3b: single press -> wave 3
    run_until_addr(8'h10);
    bus.key_sel = 1'b1; tick(); bus.key_sel = 1'b0;
    run_until_addr(8'hFF);
    check("t3b_prewrap", {30'd0, bus.wave_sel}, 32'h2);
    tick();
    check("t3b_wave", {30'd0, bus.wave_sel}, 32'h3);
    tick(); tick();
    check("t3b_dout_tri", {24'd0, bus.dout}, 32'h33);

    // 3c: press on the wrap clock applies one wrap later
    run_until_addr(8'hFF);
    bus.key_sel = 1'b1; tick(); bus.key_sel = 1'b0;
    check("t3c_addr", {24'd0, bus.rom_addr}, 32'h0);
    check("t3c_same_wrap", {30'd0, bus.wave_sel}, 32'h3);
    run_until_addr(8'hFF);
    check("t3c_prewrap", {30'd0, bus.wave_sel}, 32'h3);
    tick();
    check("t3c_wave", {30'd0, bus.wave_sel}, 32'h0);
    tick(); tick();
    check("t3c_dout_sin", {24'd0, bus.dout}, 32'h00);

    // 4: attenuation on saw
    bus.key_sel = 1'b1; tick(); tick(); bus.key_sel = 1'b0;
    run_until_addr(8'hFF);
    tick();
    check("t4_wave", {30'd0, bus.wave_sel}, 32'h2);
    bus.key_amp = 1'b1; tick(); tick(); bus.key_amp = 1'b0;
    check("t4_amp2", {30'd0, bus.amp_shift}, 32'h2);
    repeat (3) tick();
    check("t4_dout_ff", {24'd0, bus.dout}, 32'h9F);
    bus.rom_q_saw = 8'h00;
    tick(); tick();
    check("t4_dout_00", {24'd0, bus.dout}, 32'h60);
    bus.key_amp = 1'b1; tick(); bus.key_amp = 1'b0;
    check("t4_amp3", {30'd0, bus.amp_shift}, 32'h3);
    repeat (3) tick();
    check("t4_dout_s3", {24'd0, bus.dout}, 32'h70);
    bus.key_amp = 1'b1; tick(); bus.key_amp = 1'b0;
    check("t4_amp_wrap", {30'd0, bus.amp_shift}, 32'h0);
    repeat (3) tick();
    check("t4_dout_s0", {24'd0, bus.dout}, 32'h00);

    // 2: frequency steps, phase continuous
    exp_addr = bus.rom_addr;
    bus.key_freq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_addr = exp_addr + 8'(1 << k);
      check("t2_addr_chg", {24'd0, bus.rom_addr}, {24'd0, exp_addr});
      check("t2_freq", {29'd0, bus.freq_idx}, 32'(k + 1));
    end
    bus.key_freq = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      exp_addr = exp_addr + 8'd8;
      check("t2_addr", {24'd0, bus.rom_addr}, {24'd0, exp_addr});
    end
    bus.key_freq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_freq_wrap", {29'd0, bus.freq_idx}, {29'd0, 3'(4 + k)});
    end
    bus.key_freq = 1'b0;

    // 5: stop while a switch is pending
    run_until_addr(8'h20);
    bus.key_sel = 1'b1; tick(); bus.key_sel = 1'b0;
    bus.run_en = 1'b0;
    tick();
    check("t5_rden", {31'd0, bus.rom_rden}, 32'h0);
    check("t5_addr", {24'd0, bus.rom_addr}, 32'h0);
    check("t5_valid_x0", {31'd0, bus.dout_valid}, 32'h1);
    tick();
    check("t5_valid_x1", {31'd0, bus.dout_valid}, 32'h1);
    tick();
    check("t5_valid_x2", {31'd0, bus.dout_valid}, 32'h0);
    check("t5_dout_mid", {24'd0, bus.dout}, 32'h80);
    check("t5_wave", {30'd0, bus.wave_sel}, 32'h2);
    bus.run_en = 1'b1;
    tick();
    check("t5_restart", {31'd0, bus.rom_rden}, 32'h1);
    run_until_addr(8'hFF);
    tick();
    check("t5_pend_lost", {30'd0, bus.wave_sel}, 32'h2);

    // 6: asynchronous reset mid-run
    bus.key_amp = 1'b1; tick(); bus.key_amp = 1'b0;
    bus.key_freq = 1'b1; tick(); bus.key_freq = 1'b0;
    check("t6_pre_amp", {30'd0, bus.amp_shift}, 32'h1);
    check("t6_pre_freq", {29'd0, bus.freq_idx}, 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("t6");
`ifdef WAVE_SWEEP_EN
    bus.sweep_en = 1'b1;
`endif
    tick();
    rst_n = 1'b1;
    tick();

`ifdef WAVE_SWEEP_EN
    run_until_addr(8'h10);
    bus.key_freq = 1'b1; tick(); bus.key_freq = 1'b0;
    check("sw_key_ignored", {29'd0, bus.freq_idx}, 32'h0);
    run_until_addr(8'hFF);
    tick();
    check("sw_freq1", {29'd0, bus.freq_idx}, 32'h1);
    run_until_addr(8'hFE);
    tick();
    check("sw_wrap2_addr", {24'd0, bus.rom_addr}, 32'h0);
    check("sw_freq2", {29'd0, bus.freq_idx}, 32'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
